// File: rtl/mic_level_meter.sv
// mic_level_meter: converts 12-bit microphone samples to a magnitude about
// the midpoint and tracks the loudest sample of each window. At the end of
// every window it publishes the raw peak, a 0-15 level, a clip flag and a
// peak-hold level that freezes and then decays by one step per window.
// Optional build macro: MIC_DC_TRACK_EN tracks the DC midpoint with a slow
// leaky accumulator instead of using the fixed MID value.
module mic_level_meter #(
  parameter int WINDOW       = 1000,
  parameter int HOLD_WINDOWS = 10,
  parameter int MID          = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [11:0] mic_in,
  output logic [10:0] raw_peak,
  output logic [3:0]  volume_level_raw,
  output logic [3:0]  volume_level_peak,
  output logic        clip,
  output logic        update
);

  localparam int CNT_W = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] WINDOW_C = CNT_W'(WINDOW);
  localparam logic [7:0]       HOLD_C   = 8'(HOLD_WINDOWS);

  localparam logic [0:0] ACCUM  = 1'b0;
  localparam logic [0:0] COMMIT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [10:0]      accPeak_q, accPeak_d;
  logic             accClip_q, accClip_d;
  logic [10:0]      commitPeak_q, commitPeak_d;
  logic             commitClip_q, commitClip_d;
  logic [10:0]      rawPeak_q, rawPeak_d;
  logic [3:0]       levelRaw_q, levelRaw_d;
  logic [3:0]       held_q, held_d;
  logic [7:0]       holdCnt_q, holdCnt_d;
  logic             clip_q, clip_d;
  logic             update_q, update_d;

  logic [11:0]        mid;
  logic signed [12:0] diff;
  logic [12:0]        absDiff;
  logic [10:0]        mag;
  logic               sampleClip;
  logic [10:0]        peakNext;
  logic               clipNext;
  logic [CNT_W-1:0]   cntNext;
  logic [3:0]         levelNew;

`ifdef MIC_DC_TRACK_EN
  logic [19:0] dcAcc_q, dcAcc_d;
  logic [20:0] dcSum;

  assign mid = dcAcc_q[19:8];

  // Leaky average of the input: moves 1/256 of the way toward each sample
  always_comb begin
    dcSum   = {1'b0, dcAcc_q} + {9'b0, mic_in} - {9'b0, dcAcc_q[19:8]};
    dcAcc_d = dcAcc_q;
    if (sample_valid) begin
      dcAcc_d = dcSum[19:0];
    end
  end

  // DC tracker register starts at the nominal midpoint
  always_ff @(posedge clk) begin
    if (rst) begin
      dcAcc_q <= 20'(MID) << 8;
    end else begin
      dcAcc_q <= dcAcc_d;
    end
  end
`else
  assign mid = 12'(MID);
`endif

  // Distance of the sample from the midpoint, saturated to 11 bits
  always_comb begin
    diff       = $signed({1'b0, mic_in}) - $signed({1'b0, mid});
    absDiff    = diff[12] ? $unsigned(-diff) : $unsigned(diff);
    mag        = (absDiff > 13'd2047) ? 11'd2047 : absDiff[10:0];
    sampleClip = (mic_in == 12'd0) || (mic_in == 12'hFFF);
  end

  // Window accumulation; a sample in the COMMIT cycle simply starts the next window
  always_comb begin
    peakNext     = (mag > accPeak_q) ? mag : accPeak_q;
    clipNext     = accClip_q | sampleClip;
    cntNext      = cnt_q + 1'b1;
    state_d      = ACCUM;
    cnt_d        = cnt_q;
    accPeak_d    = accPeak_q;
    accClip_d    = accClip_q;
    commitPeak_d = commitPeak_q;
    commitClip_d = commitClip_q;
    if (sample_valid) begin
      if (cntNext == WINDOW_C) begin
        commitPeak_d = peakNext;
        commitClip_d = clipNext;
        accPeak_d    = 11'd0;
        accClip_d    = 1'b0;
        cnt_d        = '0;
        state_d      = COMMIT;
      end else begin
        accPeak_d = peakNext;
        accClip_d = clipNext;
        cnt_d     = cntNext;
      end
    end
  end

  // Publish the committed window and step the peak-hold tracker
  always_comb begin
    levelNew   = commitPeak_q[10:7];
    rawPeak_d  = rawPeak_q;
    levelRaw_d = levelRaw_q;
    clip_d     = clip_q;
    held_d     = held_q;
    holdCnt_d  = holdCnt_q;
    update_d   = 1'b0;
    if (state_q == COMMIT) begin
      update_d   = 1'b1;
      rawPeak_d  = commitPeak_q;
      levelRaw_d = levelNew;
      clip_d     = commitClip_q;
      if (levelNew >= held_q) begin
        held_d    = levelNew;
        holdCnt_d = HOLD_C;
      end else if (holdCnt_q != 8'd0) begin
        holdCnt_d = holdCnt_q - 8'd1;
      end else begin
        held_d = held_q - 4'd1;
      end
    end
  end

  // State registers; reset discards any partial window
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACCUM;
      cnt_q        <= '0;
      accPeak_q    <= 11'd0;
      accClip_q    <= 1'b0;
      commitPeak_q <= 11'd0;
      commitClip_q <= 1'b0;
      rawPeak_q    <= 11'd0;
      levelRaw_q   <= 4'd0;
      held_q       <= 4'd0;
      holdCnt_q    <= 8'd0;
      clip_q       <= 1'b0;
      update_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      accPeak_q    <= accPeak_d;
      accClip_q    <= accClip_d;
      commitPeak_q <= commitPeak_d;
      commitClip_q <= commitClip_d;
      rawPeak_q    <= rawPeak_d;
      levelRaw_q   <= levelRaw_d;
      held_q       <= held_d;
      holdCnt_q    <= holdCnt_d;
      clip_q       <= clip_d;
      update_q     <= update_d;
    end
  end

  assign raw_peak          = rawPeak_q;
  assign volume_level_raw  = levelRaw_q;
  assign volume_level_peak = held_q;
  assign clip              = clip_q;
  assign update            = update_q;

endmodule

// File: tb/tb_mic_level_meter.sv
// tb_mic_level_meter: drives directed and random sample streams into
// mic_level_meter (WINDOW=4, HOLD_WINDOWS=2). A window-level reference model
// queues the expected result of each completed window; a monitor on the
// falling edge pops and compares whenever update is high.
module tb_mic_level_meter;

  localparam int WINDOW       = 4;
  localparam int HOLD_WINDOWS = 2;
  localparam int MID          = 2048;

  typedef struct {
    int raw;
    int lvl;
    int peak;
    int clip;
    int cyc;
  } expT;

  logic        clk;
  logic        rst;
  logic        sample_valid;
  logic [11:0] mic_in;
  logic [10:0] raw_peak;
  logic [3:0]  volume_level_raw;
  logic [3:0]  volume_level_peak;
  logic        clip;
  logic        update;

  expT expQ[$];
  expT lastExp;
  int  nCompared;
  int  nMismatch;
  int  cycCnt;
  int  nUpdates;
  int  nWindows;

  int  winMags[$];
  int  winClip;
  int  mHeld;
  int  mHoldCnt;
  int  mDc;

  mic_level_meter #(
    .WINDOW(WINDOW),
    .HOLD_WINDOWS(HOLD_WINDOWS),
    .MID(MID)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sample_valid(sample_valid),
    .mic_in(mic_in),
    .raw_peak(raw_peak),
    .volume_level_raw(volume_level_raw),
    .volume_level_peak(volume_level_peak),
    .clip(clip),
    .update(update)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to check update latency
  always @(posedge clk) cycCnt <= cycCnt + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int magOf(input int sample, input int midVal);
    int d;
    d = sample - midVal;
    if (d < 0) d = -d;
    if (d > 2047) d = 2047;
    return d;
  endfunction

  task automatic modelReset();
    winMags.delete();
    winClip  = 0;
    mHeld    = 0;
    mHoldCnt = 0;
    mDc      = MID * 256;
    lastExp  = '{0, 0, 0, 0, 0};
  endtask

  // Window-level reference: collect magnitudes, and at WINDOW samples derive the published values
  task automatic modelAccept(input int sample);
    int midVal;
    int pk;
    int lvl;
    expT e;
`ifdef MIC_DC_TRACK_EN
    midVal = mDc / 256;
    mDc    = mDc + sample - (mDc / 256);
`else
    midVal = MID;
`endif
    winMags.push_back(magOf(sample, midVal));
    if (sample == 0 || sample == 4095) winClip = 1;
    if (winMags.size() == WINDOW) begin
      pk = 0;
      foreach (winMags[i]) if (winMags[i] > pk) pk = winMags[i];
      lvl = pk / 128;
      if (lvl > 15) lvl = 15;
      if (lvl >= mHeld) begin
        mHeld    = lvl;
        mHoldCnt = HOLD_WINDOWS;
      end else if (mHoldCnt > 0) begin
        mHoldCnt--;
      end else begin
        mHeld = (mHeld - 1 < lvl) ? lvl : mHeld - 1;
      end
      e = '{pk, lvl, mHeld, winClip, cycCnt};
      expQ.push_back(e);
      nWindows++;
      winMags.delete();
      winClip = 0;
    end
  endtask

  // One clock of stimulus; the model sees the sample once the accepting edge has passed
  task automatic applyStimulus(input logic valid, input int data);
    sample_valid = valid;
    mic_in       = 12'(data);
    @(posedge clk);
    #1;
    if (valid) modelAccept(data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, MID);
  endtask

  task automatic applyReset();
    rst          = 1'b1;
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    checkOutput("rst_raw_peak", raw_peak, 0);
    checkOutput("rst_level_raw", volume_level_raw, 0);
    checkOutput("rst_level_peak", volume_level_peak, 0);
    checkOutput("rst_clip", clip, 0);
    checkOutput("rst_update", update, 0);
  endtask

  // Monitor: compare on each update, and insist outputs hold steady otherwise
  always @(negedge clk) begin
    expT e;
    if (!rst && cycCnt > 0) begin
      if (update) begin
        nUpdates++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_update", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("raw_peak", raw_peak, e.raw);
          checkOutput("volume_level_raw", volume_level_raw, e.lvl);
          checkOutput("volume_level_peak", volume_level_peak, e.peak);
          checkOutput("clip", clip, e.clip);
          checkOutput("update_latency", cycCnt, e.cyc + 1);
          lastExp = e;
        end
      end else begin
        checkOutput("outputs_stable", {raw_peak, volume_level_raw, volume_level_peak, clip},
                    {11'(lastExp.raw), 4'(lastExp.lvl), 4'(lastExp.peak), 1'(lastExp.clip)});
      end
    end
  end

  // Hard stop in case the run stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized stream
  initial begin
    int amp;
    int len;
    int s;
    nCompared    = 0;
    nMismatch    = 0;
    cycCnt       = 0;
    nUpdates     = 0;
    nWindows     = 0;
    rst          = 1'b1;
    sample_valid = 1'b0;
    mic_in       = 12'd2048;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    applyReset();

    $display("[TB] silent window");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2048);
    idle(3);

    $display("[TB] small signal window");
    applyStimulus(1'b1, 2048);
    applyStimulus(1'b1, 2300);
    applyStimulus(1'b1, 1800);
    applyStimulus(1'b1, 2100);
    idle(3);

    $display("[TB] clipped window then hold and decay");
    applyStimulus(1'b1, 2048);
    applyStimulus(1'b1, 0);
    applyStimulus(1'b1, 2048);
    applyStimulus(1'b1, 2048);
    idle(2);
    for (int w = 0; w < 6; w++) begin
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2048);
      idle(2);
    end

    $display("[TB] back-to-back strobes, sample in commit cycle");
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, (i % 4 == 0) ? 3000 : 2048 + i);
    idle(4);

    $display("[TB] reset mid-window");
    applyStimulus(1'b1, 4095);
    applyStimulus(1'b1, 4095);
    applyReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2048);
    idle(3);

    $display("[TB] constant offset input");
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 2200);
    idle(3);

    $display("[TB] randomized stream");
    for (int b = 0; b < 80; b++) begin
      case ($urandom_range(0, 4))
        0: amp = 0;
        1: amp = 100;
        2: amp = 600;
        3: amp = 1500;
        default: amp = 2100;
      endcase
      len = $urandom_range(4, 12);
      for (int i = 0; i < len; i++) begin
        s = 2048 + $urandom_range(0, 2 * amp) - amp;
        if (s < 0) s = 0;
        if (s > 4095) s = 4095;
        if ($urandom_range(0, 30) == 0) s = ($urandom_range(0, 1) == 1) ? 4095 : 0;
        applyStimulus(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, s);
      end
    end
    idle(5);

    checkOutput("queue_drained", expQ.size(), 0);
    checkOutput("update_count", nUpdates, nWindows);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
